// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared definitions for the RC4 key path: the key_loader feeder, key_gene and
// the keystream consumer all import this package.
//   RC4_N        : size of the RC4 permutation (bytes streamed per key load)
//   KEY_MAX_DEF  : default maximum key length in bytes
//   KLEN_W_DEF   : default width of key length / write pointer (clog2(KEY_MAX+1))
//   state_e      : key_loader FSM states
// -----------------------------------------------------------------------------
package rc4_pkg;

    localparam int RC4_N       = 256;
    localparam int KEY_MAX_DEF = 16;
    localparam int KLEN_W_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/key_buf.sv
// -----------------------------------------------------------------------------
// key_buf
// KEY_MAX x 8 key register file with an append-style write pointer.
//   clk       : system clock
//   rst       : asynchronous active-high reset (clears the write pointer only)
//   wr_en_i   : append wr_data_i at the write pointer (dropped when full)
//   wr_data_i : byte to append
//   clr_i     : clear the write pointer (has priority over a write)
//   rd_idx_i  : read index
//   rd_data_o : combinational read of entry rd_idx_i
//   wp_o      : current write pointer = number of bytes held
//   full_o    : buffer holds KEY_MAX bytes
// -----------------------------------------------------------------------------
module key_buf #(
    parameter int KEY_MAX = 16,
    parameter int KLEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [7:0]        wr_data_i,
    input  logic              clr_i,
    input  logic [KLEN_W-1:0] rd_idx_i,
    output logic [7:0]        rd_data_o,
    output logic [KLEN_W-1:0] wp_o,
    output logic              full_o
);

    logic [7:0]        mem_q [KEY_MAX];
    logic [KLEN_W-1:0] wp_q;
    logic [KLEN_W-1:0] wp_d;
    logic              wr_ok;

    assign full_o = (wp_q == KLEN_W'(KEY_MAX));
    assign wr_ok  = wr_en_i && !full_o && !clr_i;
    assign wp_o   = wp_q;

    always_comb begin
        wp_d = wp_q;
        if (clr_i) begin
            wp_d = '0;
        end else if (wr_ok) begin
            wp_d = wp_q + KLEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
        end else begin
            wp_q <= wp_d;
        end
    end

    // Contents are not reset: they are meaningless until rewritten.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wp_q] <= wr_data_i;
        end
    end

    // Indices beyond KEY_MAX-1 cannot occur in normal use; guard them anyway.
    always_comb begin
        rd_data_o = 8'h00;
        if (int'(rd_idx_i) < KEY_MAX) begin
            rd_data_o = mem_q[rd_idx_i];
        end
    end

endmodule

// File: rtl/key_loader.sv
// -----------------------------------------------------------------------------
// key_loader
// Host-side feeder for the RC4 KSA generator. Collects a 1..KEY_MAX byte key,
// then streams 256 bytes key[i mod len] over a valid/ready handshake.
//   clk, rst     : clock / asynchronous active-high reset
//   key_wr_en    : append key_wr_data to the key buffer (IDLE only)
//   key_wr_data  : key byte
//   key_len      : key length, sampled on start
//   start        : begin streaming (IDLE only)
//   abort        : cancel streaming; also clears the key buffer pointer
//   key_init     : byte presented downstream (registered)
//   key_rvalid   : key_init valid
//   key_rready   : downstream accepts key_init
//   busy         : streaming in progress
//   done         : one-cycle pulse after the 256th transfer
//   err          : one-cycle pulse on a rejected start or overflow write
// -----------------------------------------------------------------------------
module key_loader
    import rc4_pkg::*;
#(
    parameter int KEY_MAX = KEY_MAX_DEF,
    parameter int KLEN_W  = KLEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_wr_en,
    input  logic [7:0]        key_wr_data,
    input  logic [KLEN_W-1:0] key_len,
    input  logic              start,
    input  logic              abort,
    output logic [7:0]        key_init,
    output logic              key_rvalid,
    input  logic              key_rready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [KLEN_W-1:0] len_q, len_d;
    logic [KLEN_W-1:0] idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        key_init_q, key_init_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              buf_wr;
    logic              buf_clr;
    logic [KLEN_W-1:0] buf_rd_idx;
    logic [7:0]        buf_rd_data;
    logic [KLEN_W-1:0] buf_wp;
    logic              buf_full;
    logic [KLEN_W-1:0] idx_next;
    logic              start_bad;

    key_buf #(
        .KEY_MAX (KEY_MAX),
        .KLEN_W  (KLEN_W)
    ) u_key_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (buf_wr),
        .wr_data_i (key_wr_data),
        .clr_i     (buf_clr),
        .rd_idx_i  (buf_rd_idx),
        .rd_data_o (buf_rd_data),
        .wp_o      (buf_wp),
        .full_o    (buf_full)
    );

    // Start is checked against the pointer before any same-cycle write lands.
    assign start_bad = (key_len == '0) || (int'(key_len) > KEY_MAX) || (key_len > buf_wp);
    assign idx_next  = (idx_q == len_q - KLEN_W'(1)) ? '0 : idx_q + KLEN_W'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        key_init_d = key_init_q;
        rvalid_d   = rvalid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        buf_wr     = 1'b0;
        buf_clr    = 1'b0;
        buf_rd_idx = '0;

        case (state_q)
            IDLE: begin
                buf_wr  = key_wr_en;
                buf_clr = abort;
                if (key_wr_en && buf_full) begin
                    err_d = 1'b1;
                end
                if (start) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        len_d      = key_len;
                        idx_d      = '0;
                        cnt_d      = '0;
                        buf_rd_idx = '0;
                        key_init_d = buf_rd_data;
                        rvalid_d   = 1'b1;
                        busy_d     = 1'b1;
                        state_d    = STREAM;
                    end
                end
            end

            STREAM: begin
                if (abort) begin
                    rvalid_d = 1'b0;
                    busy_d   = 1'b0;
                    buf_clr  = 1'b1;
                    state_d  = IDLE;
                end else if (rvalid_q && key_rready) begin
                    if (cnt_q == 8'(RC4_N - 1)) begin
                        rvalid_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        // Prefetch the next byte so transfers run every cycle.
                        idx_d      = idx_next;
                        buf_rd_idx = idx_next;
                        key_init_d = buf_rd_data;
                        cnt_d      = cnt_q + 8'd1;
                    end
                end
            end

            DONE: begin
                // Force a fresh key load before the next start.
                buf_clr = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            key_init_q <= '0;
            rvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            key_init_q <= key_init_d;
            rvalid_q   <= rvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign key_init   = key_init_q;
    assign key_rvalid = rvalid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_key_loader.sv
// -----------------------------------------------------------------------------
// tb_key_loader
// Self-checking bench for key_loader. The reference model is a byte array plus
// a fill count; the expected stream is simply key[i mod len] for i = 0..255.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_key_loader;

    localparam int KEY_MAX = 16;
    localparam int KLEN_W  = 5;

    logic              clk;
    logic              rst;
    logic              key_wr_en;
    logic [7:0]        key_wr_data;
    logic [KLEN_W-1:0] key_len;
    logic              start;
    logic              abort;
    logic [7:0]        key_init;
    logic              key_rvalid;
    logic              key_rready;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks;
    int n_errors;

    // Reference model: key bytes held and how many were accepted.
    logic [7:0] m_key [256];
    int         m_wp;

    key_loader #(
        .KEY_MAX (KEY_MAX),
        .KLEN_W  (KLEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_wr_en   (key_wr_en),
        .key_wr_data (key_wr_data),
        .key_len     (key_len),
        .start       (start),
        .abort       (abort),
        .key_init    (key_init),
        .key_rvalid  (key_rvalid),
        .key_rready  (key_rready),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        bit exp_err;
        exp_err     = (m_wp >= KEY_MAX);
        key_wr_en   = 1'b1;
        key_wr_data = b;
        @(negedge clk);
        key_wr_en   = 1'b0;
        check("wr_err", {31'd0, err}, {31'd0, exp_err});
        if (!exp_err) begin
            m_key[m_wp] = b;
            m_wp++;
        end
        $display("write %02h -> wp=%0d err_expected=%0d", b, m_wp, exp_err);
    endtask

    task automatic try_start(input int len, output bit ok);
        ok      = (len >= 1) && (len <= KEY_MAX) && (len <= m_wp);
        key_len = KLEN_W'(len);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("start_err",    {31'd0, err},        {31'd0, !ok});
        check("start_rvalid", {31'd0, key_rvalid}, {31'd0, ok});
        check("start_busy",   {31'd0, busy},       {31'd0, ok});
        $display("start len=%0d wp=%0d accepted_expected=%0d", len, m_wp, ok);
    endtask

    // Runs one stream from the first valid cycle. ready_pct sets the chance of
    // accepting each cycle; abort_at >= 0 aborts at that transfer count.
    task automatic run_stream(input int len, input int ready_pct, input int abort_at);
        int         ntx;
        int         cyc;
        bit         fin;
        bit         stalled;
        logic [7:0] held;
        ntx     = 0;
        cyc     = 0;
        fin     = 1'b0;
        stalled = 1'b0;
        held    = 8'h00;
        while (!fin && cyc < 4000) begin
            cyc++;
            check("rvalid_high", {31'd0, key_rvalid}, 32'd1);
            check("done_low",    {31'd0, done},       32'd0);
            if (stalled) begin
                check("stall_stable", {24'd0, key_init}, {24'd0, held});
            end
            if (abort_at >= 0 && ntx == abort_at) begin
                key_rready = 1'b1;
                abort      = 1'b1;
                @(negedge clk);
                abort      = 1'b0;
                key_rready = 1'b0;
                check("abort_rvalid", {31'd0, key_rvalid}, 32'd0);
                check("abort_busy",   {31'd0, busy},       32'd0);
                m_wp = 0;
                for (int i = 0; i < 3; i++) begin
                    check("abort_no_done", {31'd0, done}, 32'd0);
                    @(negedge clk);
                end
                fin = 1'b1;
            end else begin
                key_rready = ($urandom_range(99) < ready_pct);
                if (key_rready) begin
                    check("byte", {24'd0, key_init}, {24'd0, m_key[ntx % len]});
                    ntx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = key_init;
                end
                @(negedge clk);
                key_rready = 1'b0;
                if (ntx == 256) begin
                    check("end_rvalid", {31'd0, key_rvalid}, 32'd0);
                    check("end_busy",   {31'd0, busy},       32'd0);
                    check("end_done",   {31'd0, done},       32'd1);
                    @(negedge clk);
                    check("done_pulse", {31'd0, done},       32'd0);
                    check("idle_rvalid", {31'd0, key_rvalid}, 32'd0);
                    m_wp = 0;
                    fin  = 1'b1;
                end
            end
        end
        check("stream_terminated", {31'd0, fin}, 32'd1);
        $display("stream len=%0d ready_pct=%0d abort_at=%0d transfers=%0d", len, ready_pct, abort_at, ntx);
    endtask

    initial begin
        bit ok;
        n_checks    = 0;
        n_errors    = 0;
        m_wp        = 0;
        rst         = 1'b1;
        key_wr_en   = 1'b0;
        key_wr_data = 8'h00;
        key_len     = '0;
        start       = 1'b0;
        abort       = 1'b0;
        key_rready  = 1'b0;
        for (int i = 0; i < 256; i++) m_key[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rvalid",   {31'd0, key_rvalid}, 32'd0);
        check("rst_busy",     {31'd0, busy},       32'd0);
        check("rst_done",     {31'd0, done},       32'd0);
        check("rst_err",      {31'd0, err},        32'd0);
        check("rst_key_init", {24'd0, key_init},   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Rejected starts, then a fixed 5-byte key with ready always high.
        try_start(0, ok);
        for (int i = 1; i <= 5; i++) wr_byte(8'(i));
        try_start(6, ok);
        try_start(KEY_MAX + 1, ok);
        try_start(5, ok);
        if (ok) run_stream(5, 100, -1);

        // Same key, ready toggling.
        for (int i = 1; i <= 5; i++) wr_byte(8'(i));
        try_start(5, ok);
        if (ok) run_stream(5, 50, -1);

        // Overflow: 17th write dropped, full-length key.
        for (int i = 0; i < KEY_MAX + 1; i++) wr_byte(8'($urandom_range(255)));
        try_start(KEY_MAX, ok);
        if (ok) run_stream(KEY_MAX, 70, -1);

        // Abort after 100 transfers, then reload and restart from byte 0.
        for (int i = 0; i < 5; i++) wr_byte(8'($urandom_range(255)));
        try_start(3, ok);
        if (ok) run_stream(3, 60, 100);
        for (int i = 0; i < 4; i++) wr_byte(8'($urandom_range(255)));
        try_start(4, ok);
        if (ok) run_stream(4, 100, -1);

        // Randomized loads and starts.
        for (int r = 0; r < 6; r++) begin
            int nw;
            nw = $urandom_range(0, 18);
            for (int i = 0; i < nw; i++) wr_byte(8'($urandom_range(255)));
            try_start($urandom_range(0, 20), ok);
            if (ok) run_stream(int'(key_len), $urandom_range(30, 100), -1);
        end

        // Reset during a stream: outputs drop asynchronously, buffer is empty.
        for (int i = 0; i < 8; i++) wr_byte(8'($urandom_range(255)));
        try_start(8, ok);
        key_rready = 1'b1;
        repeat (20) @(negedge clk);
        key_rready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_rvalid", {31'd0, key_rvalid}, 32'd0);
        check("arst_busy",   {31'd0, busy},       32'd0);
        check("arst_done",   {31'd0, done},       32'd0);
        check("arst_err",    {31'd0, err},        32'd0);
        @(negedge clk);
        rst  = 1'b0;
        m_wp = 0;
        @(negedge clk);
        try_start(5, ok);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_loader.md
Name: key_loader

Overview:
- Host-side feeder for the RC4 key-scheduling generator `key_gene`.
- Captures a user key of 1..KEY_MAX bytes into an internal buffer.
- Then streams exactly 256 bytes over the `key_init` / `key_rvalid` / `key_rready` handshake. Byte i carries key[i mod key_len], as the RC4 KSA requires.
- Sits between the host/config interface and `key_gene`, and is the sending end of `key_gene`'s input handshake.

Parameters:
- KEY_MAX, 16, maximum key length in bytes (1..256).
- KLEN_W, 5, width of `key_len` and of the write pointer; equals clog2(KEY_MAX+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- key_wr_en  input  1  host writes one key byte this cycle.
- key_wr_data  input  8  key byte to write.
- key_len  input  KLEN_W  key length, sampled on `start`.
- start  input  1  single-cycle request to begin streaming.
- abort  input  1  cancel streaming and return to IDLE.
- key_init  output  8  key byte presented to `key_gene`.
- key_rvalid  output  1  `key_init` is valid.
- key_rready  input  1  `key_gene` accepts `key_init`.
- busy  output  1  high in STREAM.
- done  output  1  one-cycle pulse after the 256th transfer.
- err  output  1  one-cycle pulse on a rejected `start` or a buffer overflow write.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (`rst`). On reset:
  - all outputs are 0;
  - state = IDLE;
  - write pointer wp = 0, index idx = 0, count cnt = 0;
  - buffer contents are don't-care.
- Transfer rule: a transfer occurs on a rising edge where `key_rvalid` && `key_rready`.
  - While `key_rvalid`=1 and `key_rready`=0, `key_init` holds stable.
  - `key_rvalid` never drops before a transfer, except on `abort` or reset.
- States:
  - IDLE
    - `key_wr_en`: if wp<KEY_MAX, then buf[wp] <= `key_wr_data` and wp++. Otherwise the write is dropped and `err` pulses next cycle.
    - `start`: if key_len==0, key_len>KEY_MAX, or key_len>wp, then `err` pulses next cycle and the state stays IDLE.
    - `start` accepted at edge T:
      - latch len <= key_len; idx <= 0; cnt <= 0;
      - `key_init` <= buf[0]; `key_rvalid` <= 1; `busy` <= 1;
      - go to STREAM. `key_rvalid` is first high in the cycle after T.
    - `key_wr_en` and `start` in the same cycle: the write is performed, and the start check uses the old wp.
  - STREAM
    - `key_wr_en` and `start` are ignored, with no `err`.
    - On each transfer: idx <= (idx==len-1) ? 0 : idx+1; `key_init` <= buf[next idx]; cnt++.
    - Back-to-back transfers sustain one byte per cycle (`key_init` is registered, with the next byte prefetched).
    - On the transfer with cnt==255: `key_rvalid` <= 0; `busy` <= 0; go to DONE.
    - `abort` (priority over a transfer in the same cycle): `key_rvalid` <= 0; `busy` <= 0; wp <= 0; go to IDLE; no `done`.
  - DONE (1 cycle)
    - `done`=1; wp <= 0 (the key buffer must be reloaded before the next start); go to IDLE.
- `abort` in IDLE or DONE has no effect, except that in IDLE it also clears wp.
- Width rules:
  - cnt is 8 bits; terminal condition is cnt==255 at a transfer.
  - idx is KLEN_W bits and wraps at len, so len=1 repeats buf[0] 256 times.
- Reset asserted mid-STREAM: `key_rvalid` falls asynchronously; no `done`.

Decomposition:
- Package `rc4_pkg`:
  - RC4_N=256;
  - default KEY_MAX;
  - state enum {IDLE, STREAM, DONE};
  - shared by `key_gene` and its keystream consumer.
- One sub-module `key_buf`: KEY_MAX x 8 register file with write pointer, full flag, synchronous write, combinational read by index, and pointer clear.
- The FSM, counters and handshake stay in `key_loader`.

Test Plan:
- Write bytes 01,02,03,04,05; start with key_len=5; `key_rready` held 1 -> 256 consecutive transfers with sequence 01..05 repeating (byte 255 = 01); `done` pulses once, one cycle after the last transfer; `busy` low afterward.
- Same key with `key_rready` randomly toggled (~50%) -> identical 256-byte sequence; `key_init` stable whenever valid && !ready; exactly 256 transfers.
- Start with key_len=0, then key_len=6 after 5 writes, then key_len=KEY_MAX+1 -> `err` pulses each time; `key_rvalid` stays 0; state stays IDLE.
- 17 writes with KEY_MAX=16 -> the 17th write is dropped and `err` pulses; start with key_len=16 streams buf[0..15] cyclically, with byte 16 = buf[0].
- Assert `abort` after 100 transfers (simultaneous with `key_rready`=1) -> that transfer is not counted; `key_rvalid` falls next cycle; no `done`. Reload and restart -> the stream begins at buf[0].
- Assert `rst` mid-STREAM -> `key_rvalid`, `busy`, `done` and `err` are 0 immediately (asynchronously); after release, start without a reload gives `err` (wp=0).
